// File: rtl/stage_data_pkg.sv
// Shared definitions for the stage data capture blocks.
//   MODE_TRACK / MODE_RISE / MODE_FALL : capture-mode selectors.
//   sat_inc                            : saturating increment of a counter
//                                        whose width (<= 32) is given as cnt_w.
package stage_data_pkg;

   localparam int MODE_TRACK = 0;
   localparam int MODE_RISE  = 1;
   localparam int MODE_FALL  = 2;

   localparam int CNT_MAX_W  = 32;

   // Counter values are carried in a 32-bit container; the caller truncates
   // the result back to its own width.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input int cnt_w);
      logic [31:0] top;
      top = (cnt_w >= CNT_MAX_W) ? '1 : ((32'd1 << cnt_w) - 32'd1);
      return (val >= top) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/stage_edge_detect.sv
// Registers the stage-on strobe and derives its edge qualifiers.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   stageon      : stage-on strobe, synchronous to clock
//   stageon_q    : stageon delayed one cycle
//   rise         : stageon high now, low last cycle
//   fall         : stageon low now, high last cycle
//   freeze       : first cycle in which stageon_q is high (rise delayed one cycle)
module stage_edge_detect (
   input  logic clock,
   input  logic reset,
   input  logic stageon,
   output logic stageon_q,
   output logic rise,
   output logic fall,
   output logic freeze
);

   logic stageon_qq;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stageon_q  <= 1'b0;
         stageon_qq <= 1'b0;
      end else begin
         stageon_q  <= stageon;
         stageon_qq <= stageon_q;
      end
   end

   assign rise   = stageon & ~stageon_q;
   assign fall   = ~stageon & stageon_q;
   assign freeze = stageon_q & ~stageon_qq;

endmodule

// File: rtl/stage_data_capture.sv
// Captures a data bus under control of the stage-on strobe and keeps a short
// history of committed values.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   stageon      : stage-on strobe
//   clear        : synchronous clear of data, history, count and valid
//   datain       : data to capture
//   dataout      : current captured value
//   hist_out     : history, [WIDTH-1:0] newest commit, top slice oldest
//   valid        : at least one commit since reset/clear
//   new_data     : one-cycle pulse aligned with updated hist_out/cap_count
//   cap_count    : saturating commit count
module stage_data_capture
   import stage_data_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4,
   parameter int MODE  = 0,
   parameter int CNT_W = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   stageon,
   input  logic                   clear,
   input  logic [WIDTH-1:0]       datain,
   output logic [WIDTH-1:0]       dataout,
   output logic [WIDTH*DEPTH-1:0] hist_out,
   output logic                   valid,
   output logic                   new_data,
   output logic [CNT_W-1:0]       cap_count
);

   if (MODE != MODE_TRACK && MODE != MODE_RISE && MODE != MODE_FALL) begin : g_bad_mode
      $error("stage_data_capture: illegal MODE %0d", MODE);
   end
   if (WIDTH < 1 || DEPTH < 1) begin : g_bad_size
      $error("stage_data_capture: WIDTH and DEPTH must be >= 1");
   end
   if (CNT_W < 1 || CNT_W > CNT_MAX_W) begin : g_bad_cnt
      $error("stage_data_capture: CNT_W must be 1..%0d", CNT_MAX_W);
   end

   logic             stageon_q;
   logic             rise;
   logic             fall;
   logic             freeze;
   logic             ce;
   logic             cm;
   logic [WIDTH-1:0] cm_val;
   logic [WIDTH-1:0] hist [DEPTH];

   stage_edge_detect u_edge (
      .clock     (clock),
      .reset     (reset),
      .stageon   (stageon),
      .stageon_q (stageon_q),
      .rise      (rise),
      .fall      (fall),
      .freeze    (freeze)
   );

   // In TRACK mode the register is transparent while the strobe is low, so
   // the commit happens one cycle after it freezes and records the frozen
   // value rather than the live bus.
   always_comb begin
      ce     = 1'b0;
      cm     = 1'b0;
      cm_val = datain;
      case (MODE)
         MODE_TRACK: begin
            ce     = ~stageon_q;
            cm     = freeze;
            cm_val = dataout;
         end
         MODE_RISE: begin
            ce = rise;
            cm = rise;
         end
         MODE_FALL: begin
            ce = fall;
            cm = fall;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dataout <= '0;
      end else if (clear) begin
         dataout <= '0;
      end else if (ce) begin
         dataout <= datain;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid     <= 1'b0;
         new_data  <= 1'b0;
         cap_count <= '0;
      end else if (clear) begin
         valid     <= 1'b0;
         new_data  <= 1'b0;
         cap_count <= '0;
      end else begin
         new_data <= cm;
         if (cm) begin
            valid     <= 1'b1;
            cap_count <= CNT_W'(sat_inc(32'(cap_count), CNT_W));
         end
      end
   end

   // Entry 0 takes the committed value, every other entry takes its younger
   // neighbour; the oldest value simply falls off the end.
   for (genvar i = 0; i < DEPTH; i++) begin : g_hist
      logic [WIDTH-1:0] nxt;
      if (i == 0) begin : g_head
         assign nxt = cm_val;
      end else begin : g_tail
         assign nxt = hist[i-1];
      end

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            hist[i] <= '0;
         end else if (clear) begin
            hist[i] <= '0;
         end else if (cm) begin
            hist[i] <= nxt;
         end
      end

      assign hist_out[i*WIDTH +: WIDTH] = hist[i];
   end

endmodule
